// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// A fetch entry pairs a returned instruction word with the PC it was fetched from.
package if_fetch_queue_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0;
    localparam logic [31:0] NOP_INST    = 32'h0;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: PC/ROM request side, flush/stall controls and the decode-facing head.
// The slave modport is the fetch queue itself; master is whatever surrounds it.
interface if_fetch_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic          hold_o;
    logic          rom_ce_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i;
    logic          flush_i;
    logic          stall_i;
    logic          id_valid_o;
    logic [AW-1:0] id_pc_o;
    logic [DW-1:0] id_inst_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  pc_i, ce_i, rom_data_i, flush_i, stall_i,
        output hold_o, rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );

    modport master (
        output pc_i, ce_i, rom_data_i, flush_i, stall_i,
        input  hold_o, rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );
endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with a clear that empties it in one edge.
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_r [DEPTH];
    logic [PW-1:0]   rptr_r;
    logic [PW-1:0]   wptr_r;
    logic [CW-1:0]   count_r;

    // Entry storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem_r[wptr_r] <= push_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rptr_r  <= {PW{1'b0}};
            wptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (pop) begin
                rptr_r <= rptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rptr_r];
    assign count = count_r;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues ROM reads for each PC, tags returning words with their PC,
// buffers them for decode, back-pressures the PC producer and discards everything on a flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = INST_ADDR_W,
    parameter int DW    = INST_W
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          inflight_v_r;
    logic [AW-1:0] inflight_pc_r;
    logic [CW:0]   pending_s;
    logic          hold_s;
    logic          rom_ce_s;
    logic          id_valid_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;
    logic [CW-1:0] count_s;

    // Request, hold and handshake decode. Hold counts the in-flight word but ignores a
    // same-cycle pop, so a returning word always finds a free slot.
    always_comb begin
        pending_s         = {1'b0, count_s} + {{CW{1'b0}}, inflight_v_r};
        hold_s            = ~rst & (pending_s >= (CW+1)'(DEPTH));
        rom_ce_s          = bus.ce_i & ~hold_s & ~bus.flush_i & ~rst;
        id_valid_s        = (count_s != {CW{1'b0}}) & ~bus.flush_i & ~rst;
        push_s            = inflight_v_r & ~bus.flush_i;
        pop_s             = id_valid_s & ~bus.stall_i;
        push_entry_s.pc   = inflight_pc_r;
        push_entry_s.inst = bus.rom_data_i;
    end

    // In-flight tracker: the ROM answers one cycle after the request, so remember its PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_v_r  <= 1'b0;
            inflight_pc_r <= {AW{1'b0}};
        end else begin
            inflight_v_r  <= rom_ce_s;
            inflight_pc_r <= bus.pc_i;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (bus.flush_i),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (count_s)
    );

    assign bus.hold_o     = hold_s;
    assign bus.rom_ce_o   = rom_ce_s;
    assign bus.rom_addr_o = bus.pc_i;
    assign bus.id_valid_o = id_valid_s;
    assign bus.id_pc_o    = id_valid_s ? head_s.pc   : ZERO_WORD;
    assign bus.id_inst_o  = id_valid_s ? head_s.inst : NOP_INST;
    assign bus.count_o    = count_s;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a vector table for streaming and stall behaviour,
// then hand-written flush, mid-stream reset and fetch-disable sequences.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 3;
    localparam int NVEC  = 25;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if #(.AW(AW), .DW(DW), .CW(CW)) fq_if ();

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fq_if.slave)
    );

    // ROM model: mem[a] = a + 0x1000, one cycle of read latency
    always @(posedge clk) fq_if.rom_data_i <= fq_if.rom_addr_o + 32'h1000;

    typedef struct {
        logic          ce;
        logic          stall;
        logic          v;
        logic [31:0]   pc;
        logic [CW-1:0] cnt;
        logic          hold;
        logic          rce;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every decode/ROM-side output against the expected cycle state
    task automatic look(input string tag, input logic v, input logic [31:0] p,
                        input logic [CW-1:0] c, input logic h, input logic rce);
        chk({tag, ".valid"}, {31'b0, fq_if.id_valid_o}, {31'b0, v});
        chk({tag, ".pc"},    fq_if.id_pc_o, v ? p : 32'h0);
        chk({tag, ".inst"},  fq_if.id_inst_o, v ? (p + 32'h1000) : 32'h0);
        chk({tag, ".count"}, {29'b0, fq_if.count_o}, {29'b0, c});
        chk({tag, ".hold"},  {31'b0, fq_if.hold_o}, {31'b0, h});
        chk({tag, ".rom_ce"},{31'b0, fq_if.rom_ce_o}, {31'b0, rce});
        chk({tag, ".addr"},  fq_if.rom_addr_o, fq_if.pc_i);
    endtask

    // Finish the cycle: overflow guard, then PC model advances by 4 when ce & ~hold
    task automatic adv();
        logic a;
        checks++;
        if (fq_if.count_o > CW'(DEPTH)) begin
            errors++;
            $display("FAIL no_overflow: count %0d exceeds %0d", fq_if.count_o, DEPTH);
        end
        a = fq_if.ce_i & ~fq_if.hold_o;
        @(posedge clk);
        #1;
        if (a) fq_if.pc_i = fq_if.pc_i + 32'd4;
    endtask

    task automatic cyc(input string tag, input logic r, input logic ce, input logic st,
                       input logic fl, input logic v, input logic [31:0] p,
                       input logic [CW-1:0] c, input logic h, input logic rce);
        rst           = r;
        fq_if.ce_i    = ce;
        fq_if.stall_i = st;
        fq_if.flush_i = fl;
        @(negedge clk);
        look(tag, v, p, c, h, rce);
        adv();
    endtask

    initial begin
        // streaming from PC 0: two empty cycles, then one word per cycle with count 1
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1};
        for (int k = 2; k < 12; k++)
            tbl[k] = '{1'b1, 1'b0, 1'b1, 32'(4 * (k - 2)), 3'd1, 1'b0, 1'b1};
        // decode stalls for 8 cycles: fills to DEPTH, hold rises, head held at 0x28
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h28, 3'd1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h28, 3'd2, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h28, 3'd3, 1'b1, 1'b0};
        for (int k = 15; k < 20; k++)
            tbl[k] = '{1'b1, 1'b1, 1'b1, 32'h28, 3'd4, 1'b1, 1'b0};
        // release: in-order drain 0x28,0x2c,0x30,... with no gaps
        tbl[20] = '{1'b1, 1'b0, 1'b1, 32'h28, 3'd4, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 1'b1, 32'h2c, 3'd3, 1'b0, 1'b1};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 32'h30, 3'd2, 1'b0, 1'b1};
        tbl[23] = '{1'b1, 1'b0, 1'b1, 32'h34, 3'd2, 1'b0, 1'b1};
        tbl[24] = '{1'b1, 1'b0, 1'b1, 32'h38, 3'd2, 1'b0, 1'b1};

        rst           = 1'b1;
        fq_if.ce_i    = 1'b0;
        fq_if.stall_i = 1'b0;
        fq_if.flush_i = 1'b0;
        fq_if.pc_i    = 32'h0;
        @(negedge clk);
        look("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        for (int k = 0; k < NVEC; k++)
            cyc($sformatf("vec%0d", k), 1'b0, tbl[k].ce, tbl[k].stall, 1'b0,
                tbl[k].v, tbl[k].pc, tbl[k].cnt, tbl[k].hold, tbl[k].rce);

        // flush with count=3 and a word in flight; redirected PC 0x100 shows up 2 cycles later
        cyc("fl_pre",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3c, 3'd2, 1'b0, 1'b1);
        cyc("fl_cyc",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  3'd3, 1'b1, 1'b0);
        fq_if.pc_i = 32'h100;
        cyc("fl_t1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1);
        cyc("fl_t2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1);
        cyc("fl_t3",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 3'd1, 1'b0, 1'b1);
        cyc("fl_t4",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 3'd1, 1'b0, 1'b1);

        // reset mid-stream with two buffered entries
        cyc("rs_pre",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 3'd1, 1'b0, 1'b1);
        cyc("rs_cyc",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   3'd2, 1'b0, 1'b0);
        cyc("rs_t1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1);
        cyc("rs_t2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1);

        // fetch disabled for 5 cycles: no requests, two entries drain, then empty
        cyc("ce0_a",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h118, 3'd1, 1'b0, 1'b0);
        cyc("ce0_b",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h118, 3'd2, 1'b0, 1'b0);
        cyc("ce0_c",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11c, 3'd1, 1'b0, 1'b0);
        cyc("ce0_d",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0);
        cyc("ce0_e",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
